// File: rtl/cfg_chain_controller_pkg.sv
// cfg_chain_controller_pkg: shared types and sizes for the configuration chain controller
package cfg_chain_controller_pkg;
    localparam int DEF_NUM_CLB  = 4;
    localparam int DEF_CFG_BITS = 17;
    localparam int BYTE_W       = 8;
    localparam int CNT_W        = $clog2(BYTE_W);

    typedef enum logic [2:0] {
        IDLE,
        L_FETCH,
        L_SHIFT,
        L_CHK,
        R_SHIFT,
        R_EMIT
    } state_t;
endpackage

// File: rtl/cfg_bit_shifter.sv
// cfg_bit_shifter: byte register serialized or filled one bit per step, indexed by its own counter
module cfg_bit_shifter
    import cfg_chain_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              step_i,
    input  logic              cap_i,
    input  logic              ser_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              ser_o,
    output logic [CNT_W-1:0]  cnt_o
);
    logic [BYTE_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            if (cap_i) data_q[cnt_q] <= ser_i;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign data_o = data_q;
    assign ser_o  = data_q[cnt_q];
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/cfg_chain_controller.sv
// cfg_chain_controller: loads the CLB scan chain from host bytes with a trailing XOR checksum,
// and reads it back by recirculating chain_tail so the configuration survives the read.
module cfg_chain_controller
    import cfg_chain_controller_pkg::*;
#(
    parameter int NUM_CLB  = DEF_NUM_CLB,
    parameter int CFG_BITS = DEF_CFG_BITS
) (
    input  logic       prog_clk,
    input  logic       rst,
    input  logic       start_load,
    input  logic       start_read,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    input  logic       chain_tail,
    output logic       prog_in,
    output logic       prog_en,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int CHAIN_BITS = NUM_CLB * CFG_BITS;
    localparam int CW = $clog2(CHAIN_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_BITS);

    state_t            state_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [7:0]        xor_q;
    logic              cfg_ready_q, rd_valid_q, prog_en_q, done_q, err_q;
    logic              sh_load, sh_step, sh_cap, sh_ser;
    logic [7:0]        sh_load_data, sh_data;
    logic [CNT_W-1:0]  sh_cnt;
    logic              fetch_hs, last_bit, byte_end;

    assign fetch_hs = cfg_valid & cfg_ready_q;
    assign last_bit = (bit_cnt_q + CW'(1)) == LAST;
    assign byte_end = (sh_cnt == CNT_W'(BYTE_W - 1)) || last_bit;

    // Each byte starts from zero on readback so unused pad bits read as 0
    always_comb begin
        sh_load      = (state_q == L_FETCH && fetch_hs)
                    || (state_q == IDLE && !start_load && start_read)
                    || (state_q == R_EMIT && rd_ready && bit_cnt_q != LAST);
        sh_load_data = (state_q == L_FETCH) ? cfg_data : 8'h00;
        sh_step      = (state_q == L_SHIFT) || (state_q == R_SHIFT);
        sh_cap       = (state_q == R_SHIFT);
    end

    cfg_bit_shifter u_shifter (
        .clk    (prog_clk),
        .rst    (rst),
        .load_i (sh_load),
        .data_i (sh_load_data),
        .step_i (sh_step),
        .cap_i  (sh_cap),
        .ser_i  (chain_tail),
        .data_o (sh_data),
        .ser_o  (sh_ser),
        .cnt_o  (sh_cnt)
    );

    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            xor_q       <= '0;
            cfg_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            prog_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_load) begin
                        state_q     <= L_FETCH;
                        bit_cnt_q   <= '0;
                        xor_q       <= '0;
                        err_q       <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end else if (start_read) begin
                        state_q   <= R_SHIFT;
                        bit_cnt_q <= '0;
                        prog_en_q <= 1'b1;
                    end
                end
                L_FETCH: begin
                    if (fetch_hs) begin
                        state_q     <= L_SHIFT;
                        xor_q       <= xor_q ^ cfg_data;
                        cfg_ready_q <= 1'b0;
                        prog_en_q   <= 1'b1;
                    end
                end
                L_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (byte_end) begin
                        state_q     <= last_bit ? L_CHK : L_FETCH;
                        prog_en_q   <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                end
                L_CHK: begin
                    if (fetch_hs) begin
                        state_q     <= IDLE;
                        err_q       <= cfg_data != xor_q;
                        done_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                    end
                end
                R_SHIFT: begin
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (byte_end) begin
                        state_q    <= R_EMIT;
                        prog_en_q  <= 1'b0;
                        rd_valid_q <= 1'b1;
                    end
                end
                R_EMIT: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (bit_cnt_q == LAST) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= R_SHIFT;
                            prog_en_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Readback recirculates the tail straight into the head so the chain rotates in place
    assign prog_in   = (state_q == R_SHIFT) ? chain_tail : (prog_en_q & sh_ser);
    assign prog_en   = prog_en_q;
    assign cfg_ready = cfg_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = sh_data;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_cfg_chain_controller.sv
// tb_cfg_chain_controller: drives host LOAD/READ traffic against a 68-bit chain model and
// checks readback through a byte scoreboard.
module tb_cfg_chain_controller;
    localparam int NCLB = 4;
    localparam int CB   = 17;
    localparam int NB   = 68;

    logic       prog_clk = 1'b0;
    logic       rst = 1'b0, start_load = 1'b0, start_read = 1'b0, cfg_valid = 1'b0, rd_ready = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready, rd_valid, prog_in, prog_en, busy, done, err, chain_tail;
    logic [7:0] rd_data;

    logic [NB-1:0] chain = '0;
    logic [NB-1:0] exp_vec = '0;
    logic [7:0]    bytes_q [9];
    logic [7:0]    exp_q [$];
    int            en_cnt = 0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    cfg_chain_controller #(.NUM_CLB(NCLB), .CFG_BITS(CB)) dut (
        .prog_clk   (prog_clk),
        .rst        (rst),
        .start_load (start_load),
        .start_read (start_read),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .chain_tail (chain_tail),
        .prog_in    (prog_in),
        .prog_en    (prog_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: first bit shifted in ends up at chain[0], the tail of the last CLB
    assign chain_tail = chain[0];
    always @(posedge prog_clk) begin
        if (!rst) chain <= '0;
        else if (prog_en) chain <= {prog_in, chain[NB-1:1]};
        if (rst && prog_en) en_cnt++;
    end

    task automatic tick;
        @(posedge prog_clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick;
        checks++;
        if ({prog_en, prog_in, cfg_ready, rd_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got en/in/rdy/rv=%b expected 0000", {prog_en, prog_in, cfg_ready, rd_valid});
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_sts: got busy/done/err=%b expected 000", {busy, done, err});
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic do_load(input logic [7:0] chk, input int gap_max, input bit poke_read,
                           input bit both, input logic exp_err);
        int base, c0, gap;
        bit ok;
        logic [7:0] b;
        for (int k = 0; k < NB; k++) exp_vec[k] = bytes_q[k / 8][k % 8];
        base = en_cnt;
        start_load = 1'b1;
        start_read = both;
        tick;
        start_load = 1'b0;
        start_read = 1'b0;
        c0 = cyc;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_start: got err=%b busy=%b expected err=0 busy=1", err, busy);
        end
        checks++;
        if (cfg_ready !== 1'b1 || prog_en !== 1'b0) begin
            errors++;
            $display("FAIL load_taken: got cfg_ready=%b prog_en=%b expected 1 0", cfg_ready, prog_en);
        end
        for (int i = 0; i < 10; i++) begin
            b = (i < 9) ? bytes_q[i] : chk;
            if (poke_read && i == 4) begin
                start_read = 1'b1;
                tick;
                start_read = 1'b0;
            end
            gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (gap) tick;
            cfg_valid = 1'b1;
            cfg_data = b;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                if (cfg_ready) begin
                    ok = 1'b1;
                    tick;
                    break;
                end
                tick;
            end
            cfg_valid = 1'b0;
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL load_ready_timeout: byte %0d got no cfg_ready expected ready within 100 cycles", i);
            end
        end
        checks++;
        if (done !== 1'b1 || err !== exp_err) begin
            errors++;
            $display("FAIL load_done: got done=%b err=%b expected done=1 err=%b", done, err, exp_err);
        end
        checks++;
        if (en_cnt - base != NB) begin
            errors++;
            $display("FAIL load_shifts: got %0d expected %0d", en_cnt - base, NB);
        end
        if (gap_max == 0 && !poke_read) begin
            checks++;
            if (cyc - c0 != 78) begin
                errors++;
                $display("FAIL load_cycles: got %0d expected 78", cyc - c0);
            end
        end
        for (int j = 0; j < NCLB; j++) begin
            checks++;
            if (chain[(NCLB-1-j)*CB +: CB] !== exp_vec[(NCLB-1-j)*CB +: CB]) begin
                errors++;
                $display("FAIL clb%0d_cfg: got %h expected %h", j,
                         chain[(NCLB-1-j)*CB +: CB], exp_vec[(NCLB-1-j)*CB +: CB]);
            end
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: got done=%b busy=%b rd_valid=%b expected 000", done, busy, rd_valid);
        end
    endtask

    task automatic do_read(input int hold);
        int base;
        bit ok, stall_bad;
        logic [7:0] d, e;
        for (int i = 0; i < 9; i++) exp_q.push_back(i == 8 ? (bytes_q[i] & 8'h0F) : bytes_q[i]);
        base = en_cnt;
        start_read = 1'b1;
        tick;
        start_read = 1'b0;
        checks++;
        if (busy !== 1'b1 || prog_en !== 1'b1) begin
            errors++;
            $display("FAIL read_start: got busy=%b prog_en=%b expected 1 1", busy, prog_en);
        end
        for (int i = 0; i < 9; i++) begin
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (rd_valid) begin
                    ok = 1'b1;
                    break;
                end
                tick;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL read_valid_timeout: byte %0d got no rd_valid expected within 50 cycles", i);
                break;
            end
            d = rd_data;
            stall_bad = (prog_en !== 1'b0);
            repeat (hold) begin
                tick;
                if (prog_en !== 1'b0 || rd_data !== d || rd_valid !== 1'b1) stall_bad = 1'b1;
            end
            checks++;
            if (stall_bad) begin
                errors++;
                $display("FAIL read_stall: byte %0d got prog_en/data change while waiting expected stable", i);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL read_byte%0d: got %h expected %h", i, d, e);
            end
            rd_ready = 1'b1;
            tick;
            rd_ready = 1'b0;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL read_done: got %b expected 1", done);
        end
        checks++;
        if (en_cnt - base != NB) begin
            errors++;
            $display("FAIL read_shifts: got %0d expected %0d", en_cnt - base, NB);
        end
        checks++;
        if (chain !== exp_vec) begin
            errors++;
            $display("FAIL read_chain_intact: got %h expected %h", chain, exp_vec);
        end
        exp_q.delete();
        tick;
    endtask

    task automatic test_load_good;
        for (int i = 0; i < 9; i++) bytes_q[i] = 8'(i + 1);
        do_load(8'h01, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bad_checksum;
        do_load(8'hFF, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", err);
        end
    endtask

    task automatic test_readback;
        for (int i = 0; i < 8; i++) bytes_q[i] = 8'hA5;
        bytes_q[8] = 8'h05;
        do_load(8'h05, 0, 1'b0, 1'b0, 1'b0);
        do_read(0);
        do_read(0);
    endtask

    task automatic test_read_stall;
        do_read(20);
    endtask

    task automatic test_gaps;
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 9; i++) begin
            bytes_q[i] = 8'($urandom);
            x ^= bytes_q[i];
        end
        do_load(x, 5, 1'b1, 1'b0, 1'b0);
        do_read(0);
    endtask

    task automatic test_reset_mid;
        int base;
        bit ok;
        base = en_cnt;
        start_load = 1'b1;
        tick;
        start_load = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 8'h3C;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (en_cnt - base == 30) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        checks++;
        if (!ok || prog_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_load_reach: got shifts=%0d prog_en=%b expected 30 and 1", en_cnt - base, prog_en);
        end
        rst = 1'b0;
        tick;
        cfg_valid = 1'b0;
        checks++;
        if ({prog_en, busy, err, cfg_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: got en/busy/err/rdy=%b expected 0000", {prog_en, busy, err, cfg_ready});
        end
        rst = 1'b1;
        tick;
        for (int i = 0; i < 9; i++) bytes_q[i] = 8'h11 * 8'(i);
        do_load(8'h88, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_load_good;
        test_bad_checksum;
        test_readback;
        test_read_stall;
        test_gaps;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
